decode_stage: RTL and testbench
===============================

Name: decode_stage

Overview:
- Registered, parametrised instruction-decode stage for the Shenzhen-style core.
- Sits between instruction fetch and the regfile/ALU stage.
- Decodes the opcode field into control signals and registers them behind a valid/ready handshake.
- Implements the sleep mechanism in hardware: after issuing SLP, it stalls fetch for the requested number of cycles. The decode-only predecessor had no such sleep stall.

Parameters:
- INSTR_W, 32, instruction word width.
- OPC_LSB, 2, bit position of the opcode LSB.
- OPC_W, 7, opcode field width; must be ≥7.
- REG_AW, 3, register-address field width. Aa is at OPC_LSB+OPC_W; Aw immediately above Aa.
- IMM_W, 11, immediate field width. Immediate sits at bits [IMM_W-1:0] of instr[INSTR_W-1 -: IMM_W], i.e. the top IMM_W bits.
- SLP_W, 16, sleep counter width.

Ports:
- clk  in  1  core clock
- reset  in  1  asynchronous, active-high
- in_valid  in  1  fetch presents instr
- in_ready  out  1  stage accepts instr this cycle
- instr  in  INSTR_W  instruction word
- slp_reg_val  in  SLP_W  register value used as the SLPR duration (combinational regfile read of Aa)
- out_valid  out  1  decoded bundle valid
- out_ready  in  1  downstream accepts the bundle
- wr_en, is_slp, is_mov, is_jmp, use_imm, illegal  out  1 each  registered controls
- alu_op  out  2  00 add, 01 sub, 10 mul, 11 not; 00 for non-ALU ops
- aa, aw  out  REG_AW  registered register addresses
- imm  out  IMM_W  registered immediate
- sleeping  out  1  high while the sleep counter is nonzero

Behaviour:
- Opcodes (low 7 bits of the field; upper bits must be zero, otherwise the instruction is illegal):
  - NOP 0000000
  - MOVRR 0001110, MOVRI 0001111
  - JMPI 0010001
  - SLPR 0011010, SLPI 0011001
  - ADDR 1000010, ADDI 1000001
  - SUBR 1001010, SUBI 1001001
  - MULR 1010010, MULI 1010001
  - NOT 1011000
- Decode rules:
  - Every op defaults to aw = aa.
  - MOVRR: aw = instr Aw field.
  - use_imm = 1 for MOVRI, SLPI, ADDI, SUBI, MULI.
  - wr_en = 1 for MOV*, ADD*, SUB*, MUL*, NOT.
  - is_mov = 1 for MOV*; is_jmp = 1 for JMPI; is_slp = 1 for SLP*.
  - Unknown opcode: all controls 0, illegal = 1. It is still passed downstream as a bubble-like entry.
- in_ready = !sleeping && (!out_valid || out_ready), computed combinationally.
- Transfer in: on in_valid && in_ready, all outputs register on the next rising clk edge and out_valid goes to 1. Latency is 1 cycle.
- Holding: if out_valid && !out_ready, all outputs hold stable and in_ready = 0.
- Consumption: out_ready && out_valid with no new transfer in → out_valid goes to 0 next cycle. Simultaneous consume and accept → out_valid stays 1 with the new bundle, giving full throughput.
- Sleep FSM, states RUN and SLEEP:
  - Accepting SLPI loads cnt = zero-extended imm (truncated to SLP_W).
  - Accepting SLPR loads cnt = slp_reg_val, sampled in the accept cycle.
  - If the loaded value is nonzero → SLEEP.
  - In SLEEP, cnt decrements by 1 every clk, and sleeping = (cnt != 0).
  - When cnt reaches 0 → RUN, and in_ready may rise in that same cycle.
  - A duration of 0 → stay in RUN, no stall.
  - The SLP bundle itself is issued normally; sleep does not block out_ready handling of the already-issued bundle.
- Net stall: N idle accept cycles after the SLP accept cycle for duration N.
- Reset (asynchronous, any time, including mid-sleep or while holding):
  - out_valid = 0, all control outputs = 0, aa = aw = 0, imm = 0, alu_op = 00.
  - cnt = 0, state RUN, sleeping = 0.
  - in_ready = 1 as soon as reset deasserts.
- Widths: cnt never wraps below 0; the decrement is gated at 0.

Test Plan:
- Back-to-back stream of ADDI, MOVRR, NOT with out_ready = 1 held:
  - one accept per cycle;
  - bundles appear 1 cycle later in order;
  - MOVRR with Aa = 3, Aw = 5 → aa = 3, aw = 5, wr_en = 1, is_mov = 1.
- Backpressure: out_ready = 0 for 4 cycles after accepting MULI:
  - in_ready = 0 and outputs stable for those 4 cycles;
  - releasing out_ready accepts the next instruction in the same cycle.
- SLPI with imm = 3, then ADDR presented continuously:
  - SLP bundle out with is_slp = 1, use_imm = 1;
  - sleeping high for exactly 3 cycles;
  - ADDR accepted on the 4th cycle after the SLPI accept.
- SLPR with slp_reg_val = 0, then NOP:
  - no stall; NOP accepted in the next cycle.
- Opcode 1111111:
  - illegal = 1, wr_en = 0, out_valid = 1;
  - the following ADDI decodes normally with illegal = 0.
- SLPI with imm = 100, reset asserted at sleep cycle 10:
  - all outputs 0 immediately (async);
  - after deassert, in_ready = 1 and the next instruction is accepted at once.

Source files
------------

// File: rtl/decode_stage.sv
// Registered instruction-decode stage: opcode -> control bundle behind a valid/ready
// handshake, plus a sleep counter that stalls fetch after an SLPI/SLPR issues.
module decode_stage #(
    parameter int INSTR_W = 32,
    parameter int OPC_LSB = 2,
    parameter int OPC_W   = 7,
    parameter int REG_AW  = 3,
    parameter int IMM_W   = 11,
    parameter int SLP_W   = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [INSTR_W-1:0] instr,
    input  logic [SLP_W-1:0]   slp_reg_val,
    output logic               out_valid,
    input  logic               out_ready,
    output logic               wr_en,
    output logic               is_slp,
    output logic               is_mov,
    output logic               is_jmp,
    output logic               use_imm,
    output logic               illegal,
    output logic [1:0]         alu_op,
    output logic [REG_AW-1:0]  aa,
    output logic [REG_AW-1:0]  aw,
    output logic [IMM_W-1:0]   imm,
    output logic               sleeping
);

    localparam int AA_LSB = OPC_LSB + OPC_W;
    localparam int AW_LSB = AA_LSB + REG_AW;

    localparam logic [6:0] OP_NOP   = 7'b0000000;
    localparam logic [6:0] OP_MOVRR = 7'b0001110;
    localparam logic [6:0] OP_MOVRI = 7'b0001111;
    localparam logic [6:0] OP_JMPI  = 7'b0010001;
    localparam logic [6:0] OP_SLPR  = 7'b0011010;
    localparam logic [6:0] OP_SLPI  = 7'b0011001;
    localparam logic [6:0] OP_ADDR  = 7'b1000010;
    localparam logic [6:0] OP_ADDI  = 7'b1000001;
    localparam logic [6:0] OP_SUBR  = 7'b1001010;
    localparam logic [6:0] OP_SUBI  = 7'b1001001;
    localparam logic [6:0] OP_MULR  = 7'b1010010;
    localparam logic [6:0] OP_MULI  = 7'b1010001;
    localparam logic [6:0] OP_NOT   = 7'b1011000;

    typedef enum logic [1:0] {
        ALU_ADD = 2'b00,
        ALU_SUB = 2'b01,
        ALU_MUL = 2'b10,
        ALU_NOT = 2'b11
    } alu_op_e;

    typedef struct packed {
        logic              wr_en;
        logic              is_slp;
        logic              is_mov;
        logic              is_jmp;
        logic              use_imm;
        logic              illegal;
        alu_op_e           alu_op;
        logic [REG_AW-1:0] aa;
        logic [REG_AW-1:0] aw;
        logic [IMM_W-1:0]  imm;
    } bundle_t;

    typedef enum logic {
        S_RUN,
        S_SLEEP
    } state_e;

    logic [6:0]        opc;
    logic              opc_hi_zero;
    logic [REG_AW-1:0] field_aa;
    logic [REG_AW-1:0] field_aw;
    logic [IMM_W-1:0]  field_imm;
    logic              known_op;
    bundle_t           dec;
    bundle_t           bundle_q;
    logic [SLP_W-1:0]  slp_dur;
    logic              accept;
    state_e            state;
    logic [SLP_W-1:0]  cnt;

    // Reserved instruction bits carry no meaning in this stage.
    logic unused_instr;
    assign unused_instr = ^instr;

    assign opc       = instr[OPC_LSB +: 7];
    assign field_aa  = instr[AA_LSB +: REG_AW];
    assign field_aw  = instr[AW_LSB +: REG_AW];
    assign field_imm = instr[INSTR_W-1 -: IMM_W];

    // Any set bit above the 7-bit opcode makes the instruction illegal.
    generate
        if (OPC_W > 7) begin : g_opc_hi
            assign opc_hi_zero = (instr[OPC_LSB+7 +: OPC_W-7] == '0);
        end else begin : g_opc_exact
            assign opc_hi_zero = 1'b1;
        end
    endgenerate

    always_comb begin
        // NOTE: every field gets a default before the case so no latch is inferred.
        dec      = '0;
        known_op = 1'b1;
        dec.aa   = field_aa;
        dec.aw   = field_aa;
        dec.imm  = field_imm;
        case (opc)
            OP_NOP:   begin end
            OP_MOVRR: begin dec.wr_en = 1'b1; dec.is_mov = 1'b1; dec.aw = field_aw; end
            OP_MOVRI: begin dec.wr_en = 1'b1; dec.is_mov = 1'b1; dec.use_imm = 1'b1; end
            OP_JMPI:  begin dec.is_jmp = 1'b1; end
            OP_SLPR:  begin dec.is_slp = 1'b1; end
            OP_SLPI:  begin dec.is_slp = 1'b1; dec.use_imm = 1'b1; end
            OP_ADDR:  begin dec.wr_en = 1'b1; dec.alu_op = ALU_ADD; end
            OP_ADDI:  begin dec.wr_en = 1'b1; dec.alu_op = ALU_ADD; dec.use_imm = 1'b1; end
            OP_SUBR:  begin dec.wr_en = 1'b1; dec.alu_op = ALU_SUB; end
            OP_SUBI:  begin dec.wr_en = 1'b1; dec.alu_op = ALU_SUB; dec.use_imm = 1'b1; end
            OP_MULR:  begin dec.wr_en = 1'b1; dec.alu_op = ALU_MUL; end
            OP_MULI:  begin dec.wr_en = 1'b1; dec.alu_op = ALU_MUL; dec.use_imm = 1'b1; end
            OP_NOT:   begin dec.wr_en = 1'b1; dec.alu_op = ALU_NOT; end
            default:  known_op = 1'b0;
        endcase
        // Unknown encodings travel downstream as an inert entry flagged illegal.
        if (!known_op || !opc_hi_zero) begin
            dec         = '0;
            dec.illegal = 1'b1;
        end
    end

    // SLPI takes its duration from the immediate, SLPR from the Aa register read.
    assign slp_dur  = dec.use_imm ? SLP_W'(field_imm) : slp_reg_val;

    assign in_ready = !sleeping && (!out_valid || out_ready);
    assign accept   = in_valid && in_ready;

    // NOTE: sequential state is updated with non-blocking assignments only.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid <= 1'b0;
            bundle_q  <= '0;
        end else if (accept) begin
            out_valid <= 1'b1;
            bundle_q  <= dec;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_RUN;
            cnt   <= '0;
        end else begin
            case (state)
                S_RUN: begin
                    if (accept && dec.is_slp && slp_dur != '0) begin
                        cnt   <= slp_dur;
                        state <= S_SLEEP;
                    end
                end
                S_SLEEP: begin
                    if (cnt != '0) begin
                        cnt <= cnt - 1'b1;
                    end
                    // Leaving on the last count lets in_ready rise as cnt hits zero.
                    if (cnt <= SLP_W'(1)) begin
                        state <= S_RUN;
                    end
                end
            endcase
        end
    end

    assign sleeping = (state == S_SLEEP);

    assign wr_en    = bundle_q.wr_en;
    assign is_slp   = bundle_q.is_slp;
    assign is_mov   = bundle_q.is_mov;
    assign is_jmp   = bundle_q.is_jmp;
    assign use_imm  = bundle_q.use_imm;
    assign illegal  = bundle_q.illegal;
    assign alu_op   = bundle_q.alu_op;
    assign aa       = bundle_q.aa;
    assign aw       = bundle_q.aw;
    assign imm      = bundle_q.imm;

    a_hold_stable : assert property (@(posedge clk) disable iff (reset)
        out_valid && !out_ready |=> out_valid && $stable(bundle_q));

    a_sleep_stalls : assert property (@(posedge clk) disable iff (reset)
        sleeping |-> !in_ready);

endmodule

// File: tb/tb_decode_stage.sv
// Self-checking bench for decode_stage: vector table, hand-written handshake/sleep/reset
// sequences, and a random stream scored against a transaction-level model.
module tb_decode_stage;

    localparam logic [6:0] OP_NOP   = 7'b0000000;
    localparam logic [6:0] OP_MOVRR = 7'b0001110;
    localparam logic [6:0] OP_MOVRI = 7'b0001111;
    localparam logic [6:0] OP_JMPI  = 7'b0010001;
    localparam logic [6:0] OP_SLPR  = 7'b0011010;
    localparam logic [6:0] OP_SLPI  = 7'b0011001;
    localparam logic [6:0] OP_ADDR  = 7'b1000010;
    localparam logic [6:0] OP_ADDI  = 7'b1000001;
    localparam logic [6:0] OP_SUBR  = 7'b1001010;
    localparam logic [6:0] OP_SUBI  = 7'b1001001;
    localparam logic [6:0] OP_MULR  = 7'b1010010;
    localparam logic [6:0] OP_MULI  = 7'b1010001;
    localparam logic [6:0] OP_NOT   = 7'b1011000;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] instr;
    logic [15:0] slp_reg_val;
    logic        out_valid;
    logic        out_ready;
    logic        wr_en, is_slp, is_mov, is_jmp, use_imm, illegal;
    logic [1:0]  alu_op;
    logic [2:0]  aa, aw;
    logic [10:0] imm;
    logic        sleeping;

    always #5 clk = ~clk;

    decode_stage dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .instr      (instr),
        .slp_reg_val(slp_reg_val),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .wr_en      (wr_en),
        .is_slp     (is_slp),
        .is_mov     (is_mov),
        .is_jmp     (is_jmp),
        .use_imm    (use_imm),
        .illegal    (illegal),
        .alu_op     (alu_op),
        .aa         (aa),
        .aw         (aw),
        .imm        (imm),
        .sleeping   (sleeping)
    );

    // Opcode table as written in the ISA: flags = {wr, slp, mov, jmp, uimm}.
    typedef struct packed {
        logic [6:0] opc;
        logic       wr, slp, mov, jmp, uimm;
        logic [1:0] alu;
        logic       aw_field;
    } op_t;

    typedef struct {
        logic       wr, slp, mov, jmp, uimm, ill;
        logic [1:0] alu;
        logic [2:0] aa, aw;
        logic [10:0] imm;
    } exp_t;

    typedef struct {
        logic [31:0] ins;
        logic [4:0]  flags;
        logic        ill;
        logic [1:0]  alu;
        logic [2:0]  exp_aa;
        logic [2:0]  exp_aw;
    } vec_t;

    op_t   ops [13];
    vec_t  tab [16];

    int    n_pass;
    int    n_total;
    bit    m_valid;
    exp_t  m_b;
    int    sleep_left;

    bit          a;
    bit          got;
    int          acc_at;
    int          n_sleep;
    logic [31:0] w;
    int          pick;

    function automatic logic [31:0] mk(input logic [6:0] opc, input logic [2:0] ra,
                                       input logic [2:0] rw, input logic [10:0] im);
        return {im, 6'b0, rw, ra, opc, 2'b00};
    endfunction

    function automatic exp_t ref_decode(input logic [31:0] ins);
        exp_t e;
        e     = '{default: '0};
        e.ill = 1'b1;
        for (int k = 0; k < 13; k++) begin
            if (ops[k].opc == ins[8:2]) begin
                e.ill  = 1'b0;
                e.wr   = ops[k].wr;
                e.slp  = ops[k].slp;
                e.mov  = ops[k].mov;
                e.jmp  = ops[k].jmp;
                e.uimm = ops[k].uimm;
                e.alu  = ops[k].alu;
                e.aa   = ins[11:9];
                e.aw   = ops[k].aw_field ? ins[14:12] : ins[11:9];
                e.imm  = ins[31:21];
            end
        end
        return e;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    task automatic compare_outputs();
        check("sleeping", 32'(sleeping), 32'(sleep_left != 0));
        check("out_valid", 32'(out_valid), 32'(m_valid));
        if (m_valid) begin
            check("ctrl", 32'({wr_en, is_slp, is_mov, is_jmp, use_imm, illegal, alu_op}),
                  32'({m_b.wr, m_b.slp, m_b.mov, m_b.jmp, m_b.uimm, m_b.ill, m_b.alu}));
            if (!m_b.ill)
                check("fields", 32'({aa, aw, imm}), 32'({m_b.aa, m_b.aw, m_b.imm}));
        end
    endtask

    // One clock cycle: drive, check against the model, advance model and DUT.
    task automatic cycle(input bit iv, input logic [31:0] ins, input logic [15:0] srv,
                         input bit ordy, output bit acc_dut);
        bit   exp_rdy;
        bit   acc;
        exp_t d;
        in_valid    = iv;
        instr       = ins;
        slp_reg_val = srv;
        out_ready   = ordy;
        #1;
        exp_rdy = (sleep_left == 0) && (!m_valid || ordy);
        check("in_ready", 32'(in_ready), 32'(exp_rdy));
        compare_outputs();
        acc_dut = iv && in_ready;
        acc     = iv && exp_rdy;
        if (sleep_left > 0) sleep_left--;
        if (acc) begin
            d       = ref_decode(ins);
            m_b     = d;
            m_valid = 1'b1;
            if (d.slp) sleep_left = d.uimm ? int'(d.imm) : int'(srv);
        end else if (ordy) begin
            m_valid = 1'b0;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_out_valid"}, 32'(out_valid), 32'd0);
        check({tag, "_sleeping"}, 32'(sleeping), 32'd0);
        check({tag, "_ctrl"}, 32'({wr_en, is_slp, is_mov, is_jmp, use_imm, illegal, alu_op}), 32'd0);
        check({tag, "_fields"}, 32'({aa, aw, imm}), 32'd0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        ops[0]  = {OP_NOP,   5'b00000, 2'b00, 1'b0};
        ops[1]  = {OP_MOVRR, 5'b10100, 2'b00, 1'b1};
        ops[2]  = {OP_MOVRI, 5'b10101, 2'b00, 1'b0};
        ops[3]  = {OP_JMPI,  5'b00010, 2'b00, 1'b0};
        ops[4]  = {OP_SLPR,  5'b01000, 2'b00, 1'b0};
        ops[5]  = {OP_SLPI,  5'b01001, 2'b00, 1'b0};
        ops[6]  = {OP_ADDR,  5'b10000, 2'b00, 1'b0};
        ops[7]  = {OP_ADDI,  5'b10001, 2'b00, 1'b0};
        ops[8]  = {OP_SUBR,  5'b10000, 2'b01, 1'b0};
        ops[9]  = {OP_SUBI,  5'b10001, 2'b01, 1'b0};
        ops[10] = {OP_MULR,  5'b10000, 2'b10, 1'b0};
        ops[11] = {OP_MULI,  5'b10001, 2'b10, 1'b0};
        ops[12] = {OP_NOT,   5'b10000, 2'b11, 1'b0};

        // {instr, {wr,slp,mov,jmp,uimm}, illegal, alu_op, aa, aw}
        tab[0]  = '{mk(OP_ADDI,  3'd1, 3'd2, 11'd5),     5'b10001, 1'b0, 2'b00, 3'd1, 3'd1};
        tab[1]  = '{mk(OP_MOVRR, 3'd3, 3'd5, 11'd0),     5'b10100, 1'b0, 2'b00, 3'd3, 3'd5};
        tab[2]  = '{mk(OP_NOT,   3'd4, 3'd7, 11'd9),     5'b10000, 1'b0, 2'b11, 3'd4, 3'd4};
        tab[3]  = '{mk(OP_MOVRI, 3'd2, 3'd6, 11'h7ff),   5'b10101, 1'b0, 2'b00, 3'd2, 3'd2};
        tab[4]  = '{mk(OP_JMPI,  3'd0, 3'd1, 11'h123),   5'b00010, 1'b0, 2'b00, 3'd0, 3'd0};
        tab[5]  = '{mk(OP_SUBR,  3'd6, 3'd3, 11'd0),     5'b10000, 1'b0, 2'b01, 3'd6, 3'd6};
        tab[6]  = '{mk(OP_SUBI,  3'd7, 3'd0, 11'd1),     5'b10001, 1'b0, 2'b01, 3'd7, 3'd7};
        tab[7]  = '{mk(OP_MULR,  3'd5, 3'd5, 11'd0),     5'b10000, 1'b0, 2'b10, 3'd5, 3'd5};
        tab[8]  = '{mk(OP_MULI,  3'd1, 3'd4, 11'd2),     5'b10001, 1'b0, 2'b10, 3'd1, 3'd1};
        tab[9]  = '{mk(OP_ADDR,  3'd2, 3'd3, 11'd0),     5'b10000, 1'b0, 2'b00, 3'd2, 3'd2};
        tab[10] = '{mk(OP_NOP,   3'd3, 3'd1, 11'd0),     5'b00000, 1'b0, 2'b00, 3'd3, 3'd3};
        tab[11] = '{mk(7'b1111111, 3'd2, 3'd2, 11'd0),   5'b00000, 1'b1, 2'b00, 3'd0, 3'd0};
        tab[12] = '{mk(OP_ADDI,  3'd6, 3'd1, 11'h400),   5'b10001, 1'b0, 2'b00, 3'd6, 3'd6};
        tab[13] = '{mk(OP_SLPR,  3'd3, 3'd2, 11'd0),     5'b01000, 1'b0, 2'b00, 3'd3, 3'd3};
        tab[14] = '{mk(7'b0000001, 3'd1, 3'd1, 11'd0),   5'b00000, 1'b1, 2'b00, 3'd0, 3'd0};
        tab[15] = '{mk(OP_NOP,   3'd0, 3'd0, 11'd0),     5'b00000, 1'b0, 2'b00, 3'd0, 3'd0};

        n_pass = 0; n_total = 0;
        in_valid = 1'b0; out_ready = 1'b0; instr = '0; slp_reg_val = '0;
        reset = 1'b0;
        #1 reset = 1'b1;
        m_valid = 1'b0; sleep_left = 0;
        @(posedge clk); @(posedge clk); #1;
        check_all_zero("por");
        reset = 1'b0;
        #1;
        check("por_in_ready", 32'(in_ready), 32'd1);

        // Back-to-back table stream with out_ready held high.
        for (int i = 0; i < 16; i++) begin
            cycle(1'b1, tab[i].ins, 16'd0, 1'b1, a);
            check("tab_accept", 32'(a), 32'd1);
            check("tab_out_valid", 32'(out_valid), 32'd1);
            check("tab_flags", 32'({wr_en, is_slp, is_mov, is_jmp, use_imm}), 32'(tab[i].flags));
            check("tab_illegal", 32'(illegal), 32'(tab[i].ill));
            check("tab_alu_op", 32'(alu_op), 32'(tab[i].alu));
            if (!tab[i].ill) begin
                check("tab_aa", 32'(aa), 32'(tab[i].exp_aa));
                check("tab_aw", 32'(aw), 32'(tab[i].exp_aw));
                check("tab_imm", 32'(imm), 32'(tab[i].ins[31:21]));
            end
        end

        // Backpressure: hold MULI for 4 cycles, then release and accept in the same cycle.
        cycle(1'b1, mk(OP_MULI, 3'd2, 3'd3, 11'd7), 16'd0, 1'b1, a);
        check("bp_muli_accept", 32'(a), 32'd1);
        for (int k = 0; k < 4; k++) begin
            cycle(1'b1, mk(OP_ADDR, 3'd4, 3'd1, 11'd0), 16'd0, 1'b0, a);
            check("bp_stall_accept", 32'(a), 32'd0);
            check("bp_hold_imm", 32'(imm), 32'd7);
            check("bp_hold_alu", 32'(alu_op), 32'd2);
        end
        cycle(1'b1, mk(OP_ADDR, 3'd4, 3'd1, 11'd0), 16'd0, 1'b1, a);
        check("bp_release_accept", 32'(a), 32'd1);

        // SLPI 3 followed by a continuously presented ADDR.
        cycle(1'b1, mk(OP_SLPI, 3'd0, 3'd0, 11'd3), 16'd0, 1'b1, a);
        check("slpi_accept", 32'(a), 32'd1);
        check("slpi_is_slp", 32'(is_slp), 32'd1);
        check("slpi_use_imm", 32'(use_imm), 32'd1);
        n_sleep = 0; got = 1'b0; acc_at = 0;
        for (int k = 1; k <= 10 && !got; k++) begin
            if (sleeping) n_sleep++;
            cycle(1'b1, mk(OP_ADDR, 3'd1, 3'd1, 11'd0), 16'd0, 1'b1, a);
            if (a) begin
                got = 1'b1;
                acc_at = k;
            end
        end
        check("slp_accept_cycle", 32'(acc_at), 32'd4);
        check("slp_sleep_cycles", 32'(n_sleep), 32'd3);

        // Long sleep interrupted by an asynchronous reset mid-cycle.
        cycle(1'b1, mk(OP_SLPI, 3'd5, 3'd5, 11'd100), 16'd0, 1'b1, a);
        check("rst_slpi_accept", 32'(a), 32'd1);
        for (int k = 0; k < 10; k++)
            cycle(1'b1, mk(OP_ADDR, 3'd1, 3'd1, 11'd0), 16'd0, 1'b1, a);
        #2 reset = 1'b1;
        #1;
        m_valid = 1'b0; sleep_left = 0;
        check_all_zero("async_rst");
        @(posedge clk); #1;
        reset = 1'b0;
        #1;
        check("rst_in_ready", 32'(in_ready), 32'd1);
        cycle(1'b1, mk(OP_ADDI, 3'd2, 3'd0, 11'd9), 16'd0, 1'b1, a);
        check("rst_next_accept", 32'(a), 32'd1);
        check("rst_next_wr_en", 32'(wr_en), 32'd1);

        // Random stream against the model.
        for (int n = 0; n < 400; n++) begin
            w    = $urandom;
            pick = int'($urandom_range(0, 13));
            if (pick < 13) w[8:2] = ops[pick].opc;
            if (w[8:2] == OP_SLPI) w[31:21] = 11'($urandom_range(0, 6));
            cycle($urandom_range(0, 3) != 0, w, 16'($urandom_range(0, 6)),
                  $urandom_range(0, 3) != 0, a);
        end
        #1;
        compare_outputs();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
